sram_arbiter: RTL and testbench

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/sram_arbiter.sv | 133 +++++++++++++
 tb/tb_sram_arbiter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// Two-port (instruction/data) arbiter in front of a single SRAM-style memory port.
// One transaction outstanding at a time; ties alternate between the ports.
module sram_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                inst_req,
    input  logic [ADDR_W-1:0]   inst_addr,
    output logic                inst_addr_ok,
    output logic                inst_data_ok,
    output logic [DATA_W-1:0]   inst_rdata,

    input  logic                data_req,
    input  logic                data_wr,
    input  logic [DATA_W/8-1:0] data_wstrb,
    input  logic [ADDR_W-1:0]   data_addr,
    input  logic [DATA_W-1:0]   data_wdata,
    output logic                data_addr_ok,
    output logic                data_data_ok,
    output logic [DATA_W-1:0]   data_rdata,

    output logic                mem_req,
    output logic                mem_wr,
    output logic [DATA_W/8-1:0] mem_wstrb,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_gnt,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata
);

    typedef enum logic [1:0] {StIdle, StReq, StResp} state_e;

    state_e                state_q, state_d;
    logic                  last_inst_q;  // 1 = instruction port was served most recently
    logic                  port_data_q;  // 1 = outstanding transaction belongs to data port
    logic                  wr_q;
    logic [DATA_W/8-1:0]   wstrb_q;
    logic [ADDR_W-1:0]     addr_q;
    logic [DATA_W-1:0]     wdata_q;
    logic                  inst_ok_q, data_ok_q;
    logic [DATA_W-1:0]     inst_rdata_q, data_rdata_q;
    logic                  resp_done;

    always_comb begin
        state_d      = state_q;
        inst_addr_ok = 1'b0;
        data_addr_ok = 1'b0;
        mem_req      = 1'b0;
        resp_done    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!rst) begin
                    inst_addr_ok = inst_req && (!data_req || !last_inst_q);
                    data_addr_ok = data_req && (!inst_req || last_inst_q);
                    if (inst_addr_ok || data_addr_ok) begin
                        state_d = StReq;
                    end
                end
            end
            StReq: begin
                mem_req = !rst;
                if (mem_gnt) begin
                    state_d = StResp;
                end
            end
            StResp: begin
                if (mem_rvalid) begin
                    resp_done = 1'b1;
                    state_d   = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Memory-side fields read as zero whenever no request is presented.
    assign mem_wr    = mem_req & wr_q;
    assign mem_wstrb = mem_req ? wstrb_q : '0;
    assign mem_addr  = mem_req ? addr_q  : '0;
    assign mem_wdata = mem_req ? wdata_q : '0;

    assign inst_data_ok = inst_ok_q;
    assign data_data_ok = data_ok_q;
    assign inst_rdata   = inst_rdata_q;
    assign data_rdata   = data_rdata_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            last_inst_q  <= 1'b1;
            port_data_q  <= 1'b0;
            wr_q         <= 1'b0;
            wstrb_q      <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            inst_ok_q    <= 1'b0;
            data_ok_q    <= 1'b0;
            inst_rdata_q <= '0;
            data_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            inst_ok_q <= resp_done && !port_data_q;
            data_ok_q <= resp_done && port_data_q;
            if (data_addr_ok) begin
                port_data_q <= 1'b1;
                last_inst_q <= 1'b0;
                wr_q        <= data_wr;
                wstrb_q     <= data_wstrb;
                addr_q      <= data_addr;
                wdata_q     <= data_wdata;
            end else if (inst_addr_ok) begin
                port_data_q <= 1'b0;
                last_inst_q <= 1'b1;
                wr_q        <= 1'b0;
                wstrb_q     <= '0;
                addr_q      <= inst_addr;
                wdata_q     <= '0;
            end
            if (resp_done && !wr_q) begin
                if (port_data_q) begin
                    data_rdata_q <= mem_rdata;
                end else begin
                    inst_rdata_q <= mem_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: reset, single reads, ties, delayed-grant write,
// continuous alternation and reset while a response is pending.
module tb_sram_arbiter;

    logic        clk;
    logic        rst;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req, data_wr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        mem_req, mem_wr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_gnt, mem_rvalid;
    logic [31:0] mem_rdata;

    int checks   = 0;
    int failures = 0;

    sram_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_wstrb   (data_wstrb),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .mem_req      (mem_req),
        .mem_wr       (mem_wr),
        .mem_wstrb    (mem_wstrb),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_gnt      (mem_gnt),
        .mem_rvalid   (mem_rvalid),
        .mem_rdata    (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Two reset cycles with both ports requesting: nothing may be accepted meanwhile.
    task automatic do_reset();
        rst = 1'b1;
        inst_req = 1'b1;
        data_req = 1'b1;
        tick();
        #1;
        chk1("rst_inst_addr_ok", inst_addr_ok, 1'b0);
        chk1("rst_data_addr_ok", data_addr_ok, 1'b0);
        chk1("rst_mem_req", mem_req, 1'b0);
        tick();
        rst = 1'b0;
        inst_req = 1'b0;
        data_req = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        inst_req = 1'b0;  inst_addr = '0;
        data_req = 1'b0;  data_wr = 1'b0;  data_wstrb = '0;
        data_addr = '0;   data_wdata = '0;
        mem_gnt = 1'b0;   mem_rvalid = 1'b0;  mem_rdata = '0;

        // Reset state
        do_reset();
        #1;
        chk1("reset_inst_data_ok", inst_data_ok, 1'b0);
        chk1("reset_data_data_ok", data_data_ok, 1'b0);
        chk32("reset_inst_rdata", inst_rdata, 32'h0);
        chk32("reset_data_rdata", data_rdata, 32'h0);
        chk32("reset_mem_addr", mem_addr, 32'h0);

        // Single instruction read, minimum latency
        inst_req = 1'b1;  inst_addr = 32'hBFC00000;
        #1;
        chk1("t1_c0_inst_addr_ok", inst_addr_ok, 1'b1);
        chk1("t1_c0_data_addr_ok", data_addr_ok, 1'b0);
        chk1("t1_c0_mem_req", mem_req, 1'b0);
        tick();
        inst_req = 1'b0;  mem_gnt = 1'b1;
        #1;
        chk1("t1_c1_mem_req", mem_req, 1'b1);
        chk32("t1_c1_mem_addr", mem_addr, 32'hBFC00000);
        chk1("t1_c1_mem_wr", mem_wr, 1'b0);
        chk32("t1_c1_mem_wstrb", 32'(mem_wstrb), 32'h0);
        chk1("t1_c1_inst_addr_ok", inst_addr_ok, 1'b0);
        tick();
        mem_gnt = 1'b0;  mem_rvalid = 1'b1;  mem_rdata = 32'h3C080001;
        #1;
        chk1("t1_c2_mem_req", mem_req, 1'b0);
        chk32("t1_c2_mem_addr", mem_addr, 32'h0);
        chk1("t1_c2_inst_data_ok", inst_data_ok, 1'b0);
        tick();
        mem_rvalid = 1'b0;  mem_rdata = 32'hFFFFFFFF;
        #1;
        chk1("t1_c3_inst_data_ok", inst_data_ok, 1'b1);
        chk32("t1_c3_inst_rdata", inst_rdata, 32'h3C080001);
        chk1("t1_c3_data_data_ok", data_data_ok, 1'b0);
        tick();
        chk1("t1_c4_inst_data_ok", inst_data_ok, 1'b0);
        chk32("t1_c4_inst_rdata_hold", inst_rdata, 32'h3C080001);

        // Simultaneous reads after reset: data first, inst accepted in data_ok cycle
        do_reset();
        inst_req = 1'b1;  inst_addr = 32'hBFC00004;
        data_req = 1'b1;  data_wr = 1'b0;  data_addr = 32'h80000010;
        #1;
        chk1("t2_data_addr_ok", data_addr_ok, 1'b1);
        chk1("t2_inst_addr_ok", inst_addr_ok, 1'b0);
        tick();
        data_req = 1'b0;  mem_gnt = 1'b1;
        #1;
        chk32("t2_mem_addr_d", mem_addr, 32'h80000010);
        chk1("t2_busy_inst_addr_ok", inst_addr_ok, 1'b0);
        tick();
        mem_gnt = 1'b0;  mem_rvalid = 1'b1;  mem_rdata = 32'hDDDD0001;
        tick();
        mem_rvalid = 1'b0;
        #1;
        chk1("t2_data_data_ok", data_data_ok, 1'b1);
        chk32("t2_data_rdata", data_rdata, 32'hDDDD0001);
        chk1("t2_inst_addr_ok_concurrent", inst_addr_ok, 1'b1);
        chk1("t2_inst_data_ok_early", inst_data_ok, 1'b0);
        tick();
        inst_req = 1'b0;  mem_gnt = 1'b1;
        #1;
        chk32("t2_mem_addr_i", mem_addr, 32'hBFC00004);
        chk1("t2_data_data_ok_once", data_data_ok, 1'b0);
        tick();
        mem_gnt = 1'b0;  mem_rvalid = 1'b1;  mem_rdata = 32'h11110002;
        tick();
        mem_rvalid = 1'b0;
        #1;
        chk1("t2_inst_data_ok", inst_data_ok, 1'b1);
        chk32("t2_inst_rdata", inst_rdata, 32'h11110002);
        chk1("t2_data_data_ok_late", data_data_ok, 1'b0);
        chk32("t2_data_rdata_hold", data_rdata, 32'hDDDD0001);
        tick();

        // Data write with grant delayed 4 cycles; spurious rvalid during REQ
        data_req = 1'b1;  data_wr = 1'b1;  data_wstrb = 4'b0011;
        data_addr = 32'h80001000;  data_wdata = 32'h0000BEEF;
        #1;
        chk1("t3_data_addr_ok", data_addr_ok, 1'b1);
        tick();
        data_req = 1'b0;  data_wr = 1'b0;  data_wstrb = 4'hF;
        data_addr = 32'h12345678;  data_wdata = 32'hCAFEF00D;
        mem_rvalid = 1'b1;  mem_rdata = 32'hEEEEEEEE;
        for (int i = 0; i < 5; i++) begin
            mem_gnt = (i == 4);
            #1;
            chk1("t3_mem_req", mem_req, 1'b1);
            chk1("t3_mem_wr", mem_wr, 1'b1);
            chk32("t3_mem_wstrb", 32'(mem_wstrb), 32'h3);
            chk32("t3_mem_addr", mem_addr, 32'h80001000);
            chk32("t3_mem_wdata", mem_wdata, 32'h0000BEEF);
            tick();
            mem_rvalid = 1'b0;
        end
        mem_gnt = 1'b0;  mem_rvalid = 1'b1;  mem_rdata = 32'hFFFFFFFF;
        #1;
        chk1("t3_resp_mem_req", mem_req, 1'b0);
        chk1("t3_no_early_ok", data_data_ok, 1'b0);
        tick();
        mem_rvalid = 1'b0;
        #1;
        chk1("t3_data_data_ok", data_data_ok, 1'b1);
        chk32("t3_data_rdata_unchanged", data_rdata, 32'hDDDD0001);
        tick();

        // Continuous requests on both ports: grants alternate data/inst
        do_reset();
        inst_req = 1'b1;  inst_addr = 32'h00000100;
        data_req = 1'b1;  data_wr = 1'b0;  data_addr = 32'h00000200;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk1("t5_data_addr_ok", data_addr_ok, (i % 2) == 0);
            chk1("t5_inst_addr_ok", inst_addr_ok, (i % 2) == 1);
            tick();
            mem_gnt = 1'b1;
            #1;
            chk32("t5_mem_addr", mem_addr, ((i % 2) == 0) ? 32'h200 : 32'h100);
            tick();
            mem_gnt = 1'b0;  mem_rvalid = 1'b1;  mem_rdata = 32'hA0000000 + 32'(i);
            tick();
            mem_rvalid = 1'b0;
            #1;
            if ((i % 2) == 0) begin
                chk1("t5_data_data_ok", data_data_ok, 1'b1);
                chk32("t5_data_rdata", data_rdata, 32'hA0000000 + 32'(i));
            end else begin
                chk1("t5_inst_data_ok", inst_data_ok, 1'b1);
                chk32("t5_inst_rdata", inst_rdata, 32'hA0000000 + 32'(i));
            end
        end
        inst_req = 1'b0;  data_req = 1'b0;
        tick();

        // Reset while in RESP, then a late rvalid
        data_req = 1'b1;  data_wr = 1'b0;  data_addr = 32'h00000040;
        #1;
        chk1("t6_data_addr_ok", data_addr_ok, 1'b1);
        tick();
        data_req = 1'b0;  mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;  rst = 1'b1;
        #1;
        chk1("t6_rst_mem_req", mem_req, 1'b0);
        tick();
        rst = 1'b0;  mem_rvalid = 1'b1;  mem_rdata = 32'h00000BAD;
        tick();
        mem_rvalid = 1'b0;
        inst_req = 1'b1;  inst_addr = 32'h00000044;
        #1;
        chk1("t6_no_data_ok", data_data_ok, 1'b0);
        chk32("t6_data_rdata_cleared", data_rdata, 32'h0);
        chk1("t6_idle_inst_addr_ok", inst_addr_ok, 1'b1);
        tick();
        inst_req = 1'b0;  mem_gnt = 1'b1;
        #1;
        chk32("t6_mem_addr", mem_addr, 32'h00000044);
        tick();
        mem_gnt = 1'b0;  mem_rvalid = 1'b1;  mem_rdata = 32'h00005555;
        tick();
        mem_rvalid = 1'b0;
        #1;
        chk1("t6_inst_data_ok", inst_data_ok, 1'b1);
        chk32("t6_inst_rdata", inst_rdata, 32'h00005555);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
